// File: rtl/midi_voices_pkg.sv
// Shared MIDI decode constants and envelope state type for the polyphonic voice front end.
package midi_voices_pkg;

   localparam int MIDI_BYTES = 24;

   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] CC         = 4'hB;
   localparam logic [3:0] PITCH_BEND = 4'hE;

   localparam logic [7:0] CC_MOD        = 8'h01;
   localparam logic [7:0] CC_ATTACK     = 8'h46;
   localparam logic [7:0] CC_DECAY      = 8'h47;
   localparam logic [7:0] CC_SUSTAIN    = 8'h48;
   localparam logic [7:0] CC_RELEASE    = 8'h49;
   localparam logic [7:0] ALL_NOTES_OFF = 8'h7B;

   typedef enum logic [2:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_DECAY,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   // A voice whose key is still held, i.e. one that a note-off can move to release.
   function automatic logic is_gate_on(input env_state_t s);
      return (s == ENV_ATTACK) || (s == ENV_DECAY) || (s == ENV_SUSTAIN);
   endfunction

endpackage

// File: rtl/midi_voices_adsr_env.sv
// Per-voice ADSR envelope: event transitions take priority over the periodic tick.
module adsr_env
   import midi_voices_pkg::*;
#(
   parameter int ENV_WIDTH  = 16,
   parameter int STEP_SHIFT = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 tick,
   input  logic                 trigger,
   input  logic                 note_release,
   input  logic [6:0]           attack_time,
   input  logic [6:0]           decay_time,
   input  logic [6:0]           sustain_level,
   input  logic [6:0]           release_time,
   output logic [ENV_WIDTH-1:0] level,
   output env_state_t           state
);

   localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

   logic [6:0]           rate_time;
   logic [7:0]           rate_base;
   logic [ENV_WIDTH-1:0] step;
   logic [ENV_WIDTH-1:0] sus_target;
   logic [ENV_WIDTH:0]   up_sum;
   logic [ENV_WIDTH:0]   down_diff;

   always_comb begin
      rate_time = attack_time;
      case (state)
         ENV_DECAY:   rate_time = decay_time;
         ENV_RELEASE: rate_time = release_time;
         default:     rate_time = attack_time;
      endcase
   end

   // Longer times give smaller steps; time 127 is the slowest slope of one unit before shifting.
   assign rate_base  = 8'd128 - {1'b0, rate_time};
   assign step       = ENV_WIDTH'(rate_base) << STEP_SHIFT;
   assign sus_target = {sustain_level, {(ENV_WIDTH-7){1'b0}}};
   assign up_sum     = {1'b0, level} + {1'b0, step};
   assign down_diff  = {1'b0, level} - {1'b0, step};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= ENV_IDLE;
         level <= '0;
      end else if (trigger) begin
         state <= ENV_ATTACK;
      end else if (note_release) begin
         if (state != ENV_IDLE) state <= ENV_RELEASE;
      end else if (tick) begin
         case (state)
            ENV_IDLE: level <= '0;
            ENV_ATTACK: begin
               if (up_sum[ENV_WIDTH] || (up_sum[ENV_WIDTH-1:0] == ENV_MAX)) begin
                  level <= ENV_MAX;
                  state <= ENV_DECAY;
               end else begin
                  level <= up_sum[ENV_WIDTH-1:0];
               end
            end
            ENV_DECAY: begin
               if (down_diff[ENV_WIDTH] || (down_diff[ENV_WIDTH-1:0] <= sus_target)) begin
                  level <= sus_target;
                  state <= ENV_SUSTAIN;
               end else begin
                  level <= down_diff[ENV_WIDTH-1:0];
               end
            end
            ENV_SUSTAIN: level <= sus_target;
            ENV_RELEASE: begin
               if (down_diff[ENV_WIDTH] || (down_diff[ENV_WIDTH-1:0] == '0)) begin
                  level <= '0;
                  state <= ENV_IDLE;
               end else begin
                  level <= down_diff[ENV_WIDTH-1:0];
               end
            end
            default: state <= ENV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/midi_voices.sv
// Polyphonic MIDI front end: channel filter, voice allocation with stealing, CC registers
// and a shared envelope tick feeding one ADSR per voice.
module midi_voices
   import midi_voices_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int ENV_WIDTH  = 16,
   parameter int CHANNEL    = 0,
   parameter int TICK_DIV   = 1024,
   parameter int STEP_SHIFT = 2
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic [MIDI_BYTES-1:0]           midi_event,
   input  logic                            midi_valid_in,
   output logic [NUM_VOICES*7-1:0]         voice_note_out,
   output logic [NUM_VOICES*7-1:0]         voice_vel_out,
   output logic [NUM_VOICES*ENV_WIDTH-1:0] voice_env_out,
   output logic [NUM_VOICES-1:0]           voice_active_out,
   output logic [13:0]                     pitchbend_out,
   output logic [6:0]                      mod_out
);

   localparam int PTR_W  = $clog2(NUM_VOICES);
   localparam int TICK_W = $clog2(TICK_DIV);

   logic [3:0]        kind;
   logic [3:0]        chan;
   logic [7:0]        data1;
   logic [7:0]        data2;
   logic              accept;
   logic              note_on;
   logic              note_off;
   logic              cc_event;
   logic              all_off;
   logic              tick;
   logic [TICK_W-1:0] tick_cnt;
   logic [PTR_W-1:0]  steal_ptr;
   logic [PTR_W-1:0]  match_idx;
   logic [PTR_W-1:0]  idle_idx;
   logic [PTR_W-1:0]  rel_idx;
   logic [PTR_W-1:0]  target;
   logic              found_match;
   logic              found_idle;
   logic              found_rel;
   logic [6:0]        attack_time;
   logic [6:0]        decay_time;
   logic [6:0]        sustain_level;
   logic [6:0]        release_time;

   logic [NUM_VOICES-1:0] trigger;
   logic [NUM_VOICES-1:0] release_req;
   logic [6:0]            note_q    [NUM_VOICES];
   logic [6:0]            vel_q     [NUM_VOICES];
   logic [ENV_WIDTH-1:0]  env_level [NUM_VOICES];
   env_state_t            env_state [NUM_VOICES];

   assign kind     = midi_event[23:20];
   assign chan     = midi_event[19:16];
   assign data1    = midi_event[15:8];
   assign data2    = midi_event[7:0];
   assign accept   = midi_valid_in && (chan == 4'(CHANNEL));
   assign note_on  = accept && (kind == NOTE_ON) && (data2 != 8'd0);
   assign note_off = accept && ((kind == NOTE_OFF) || ((kind == NOTE_ON) && (data2 == 8'd0)));
   assign cc_event = accept && (kind == CC);
   assign all_off  = cc_event && (data1 == ALL_NOTES_OFF);
   assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));

   // Scanning from the top down lets the lowest matching index overwrite the others.
   always_comb begin
      found_match = 1'b0;
      found_idle  = 1'b0;
      found_rel   = 1'b0;
      match_idx   = '0;
      idle_idx    = '0;
      rel_idx     = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if ((env_state[i] != ENV_IDLE) && (note_q[i] == data1[6:0])) begin
            found_match = 1'b1;
            match_idx   = PTR_W'(i);
         end
         if (env_state[i] == ENV_IDLE) begin
            found_idle = 1'b1;
            idle_idx   = PTR_W'(i);
         end
         if (env_state[i] == ENV_RELEASE) begin
            found_rel = 1'b1;
            rel_idx   = PTR_W'(i);
         end
      end
      if (found_match)     target = match_idx;
      else if (found_idle) target = idle_idx;
      else if (found_rel)  target = rel_idx;
      else                 target = steal_ptr;
   end

   always_comb begin
      trigger     = '0;
      release_req = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         trigger[i]     = note_on && (target == PTR_W'(i));
         release_req[i] = (note_off && (note_q[i] == data1[6:0]) && is_gate_on(env_state[i]))
                       || (all_off && (env_state[i] != ENV_IDLE));
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tick_cnt  <= '0;
         steal_ptr <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (note_on && !found_match && !found_idle && !found_rel)
            steal_ptr <= (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (trigger[i]) begin
               note_q[i] <= data1[6:0];
               vel_q[i]  <= data2[6:0];
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pitchbend_out <= 14'h2000;
         mod_out       <= '0;
         attack_time   <= '0;
         decay_time    <= '0;
         sustain_level <= 7'd127;
         release_time  <= '0;
      end else begin
         if (accept && (kind == PITCH_BEND)) pitchbend_out <= {data2[6:0], data1[6:0]};
         if (cc_event) begin
            case (data1)
               CC_MOD:     mod_out       <= data2[6:0];
               CC_ATTACK:  attack_time   <= data2[6:0];
               CC_DECAY:   decay_time    <= data2[6:0];
               CC_SUSTAIN: sustain_level <= data2[6:0];
               CC_RELEASE: release_time  <= data2[6:0];
               default:    ;
            endcase
         end
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      adsr_env #(
         .ENV_WIDTH  (ENV_WIDTH),
         .STEP_SHIFT (STEP_SHIFT)
      ) u_env (
         .clk_in        (clk_in),
         .rst_n_in      (rst_n_in),
         .tick          (tick),
         .trigger       (trigger[v]),
         .note_release  (release_req[v]),
         .attack_time   (attack_time),
         .decay_time    (decay_time),
         .sustain_level (sustain_level),
         .release_time  (release_time),
         .level         (env_level[v]),
         .state         (env_state[v])
      );
      assign voice_note_out[v*7 +: 7]                = note_q[v];
      assign voice_vel_out[v*7 +: 7]                 = vel_q[v];
      assign voice_env_out[v*ENV_WIDTH +: ENV_WIDTH] = env_level[v];
      assign voice_active_out[v]                     = (env_state[v] != ENV_IDLE);
   end

endmodule

// File: tb/tb_midi_voices.sv
// Directed bench for midi_voices: allocation, stealing, CCs, envelope shape and async reset.
module tb_midi_voices;

   logic        clk_in        = 1'b0;
   logic        rst_n_in      = 1'b0;
   logic [23:0] midi_event    = '0;
   logic        midi_valid_in = 1'b0;
   logic [27:0] voice_note_out;
   logic [27:0] voice_vel_out;
   logic [63:0] voice_env_out;
   logic [3:0]  voice_active_out;
   logic [13:0] pitchbend_out;
   logic [6:0]  mod_out;

   int checks   = 0;
   int failures = 0;

   midi_voices #(
      .NUM_VOICES (4),
      .ENV_WIDTH  (16),
      .CHANNEL    (0),
      .TICK_DIV   (2),
      .STEP_SHIFT (2)
   ) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .midi_event       (midi_event),
      .midi_valid_in    (midi_valid_in),
      .voice_note_out   (voice_note_out),
      .voice_vel_out    (voice_vel_out),
      .voice_env_out    (voice_env_out),
      .voice_active_out (voice_active_out),
      .pitchbend_out    (pitchbend_out),
      .mod_out          (mod_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] env_of(input int i);
      return voice_env_out[i*16 +: 16];
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] status, input logic [7:0] d1, input logic [7:0] d2);
      @(negedge clk_in);
      midi_event    = {status, d1, d2};
      midi_valid_in = 1'b1;
      @(negedge clk_in);
      midi_valid_in = 1'b0;
      midi_event    = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic wait_env(input string tag, input int idx, input logic [15:0] value, input int limit);
      for (int c = 0; c < limit; c++) begin
         if (env_of(idx) == value) break;
         @(negedge clk_in);
      end
      check_output(tag, env_of(idx), value);
   endtask

   task automatic wait_all_idle(input string tag, input int limit);
      for (int c = 0; c < limit; c++) begin
         if (voice_active_out == 4'b0000) break;
         @(negedge clk_in);
      end
      check_output(tag, voice_active_out, 4'b0000);
   endtask

   initial begin
      logic [15:0] lvl;

      wait_cycles(3);
      check_output("reset_notes", voice_note_out, 28'h0);
      check_output("reset_vel", voice_vel_out, 28'h0);
      check_output("reset_env", voice_env_out, 64'h0);
      check_output("reset_active", voice_active_out, 4'b0000);
      check_output("reset_pitchbend", pitchbend_out, 14'h2000);
      check_output("reset_mod", mod_out, 7'h00);
      rst_n_in = 1'b1;

      apply_stimulus(8'h90, 8'd60, 8'd100);
      apply_stimulus(8'h90, 8'd64, 8'd100);
      apply_stimulus(8'h90, 8'd67, 8'd100);
      apply_stimulus(8'h90, 8'd71, 8'd100);
      check_output("fill_notes", voice_note_out, {7'd71, 7'd67, 7'd64, 7'd60});
      check_output("fill_active", voice_active_out, 4'b1111);
      check_output("fill_vel", voice_vel_out, {7'd100, 7'd100, 7'd100, 7'd100});

      apply_stimulus(8'h90, 8'd72, 8'd100);
      check_output("steal_ptr0", voice_note_out, {7'd71, 7'd67, 7'd64, 7'd72});
      apply_stimulus(8'h90, 8'd74, 8'd90);
      check_output("steal_ptr1", voice_note_out, {7'd71, 7'd67, 7'd74, 7'd72});
      check_output("steal_ptr1_vel", voice_vel_out[13:7], 7'd90);

      apply_stimulus(8'h90, 8'd74, 8'd0);
      check_output("vel0_off_active", voice_active_out, 4'b1111);
      check_output("vel0_off_note_hold", voice_note_out[13:7], 7'd74);
      lvl = env_of(1);
      wait_cycles(2);
      check_output("vel0_off_release_step", env_of(1), lvl - 16'd512);

      apply_stimulus(8'h90, 8'd50, 8'd80);
      check_output("release_first_steal", voice_note_out, {7'd71, 7'd67, 7'd50, 7'd72});
      check_output("release_first_vel", voice_vel_out[13:7], 7'd80);
      apply_stimulus(8'h90, 8'd52, 8'd80);
      check_output("steal_ptr2", voice_note_out, {7'd71, 7'd52, 7'd50, 7'd72});

      apply_stimulus(8'h93, 8'd60, 8'd100);
      apply_stimulus(8'hB3, 8'h01, 8'h55);
      check_output("other_channel_notes", voice_note_out, {7'd71, 7'd52, 7'd50, 7'd72});
      check_output("other_channel_mod", mod_out, 7'h00);

      apply_stimulus(8'hE0, 8'h7F, 8'h7F);
      check_output("pitchbend_max", pitchbend_out, 14'h3FFF);
      apply_stimulus(8'hE0, 8'h05, 8'h12);
      check_output("pitchbend_mix", pitchbend_out, 14'h0905);
      apply_stimulus(8'hB0, 8'h01, 8'h2A);
      check_output("cc_mod", mod_out, 7'h2A);

      check_output("pre_all_off_active", voice_active_out, 4'b1111);
      apply_stimulus(8'hB0, 8'h7B, 8'h00);
      wait_all_idle("all_notes_off_idle", 2000);
      check_output("all_notes_off_env", voice_env_out, 64'h0);
      check_output("all_notes_off_notes_hold", voice_note_out, {7'd71, 7'd52, 7'd50, 7'd72});

      apply_stimulus(8'hB0, 8'h46, 8'd127);
      apply_stimulus(8'hB0, 8'h47, 8'd127);
      apply_stimulus(8'hB0, 8'h48, 8'd64);
      apply_stimulus(8'hB0, 8'h49, 8'd127);
      apply_stimulus(8'h90, 8'd60, 8'd100);
      check_output("shape_alloc_note", voice_note_out[6:0], 7'd60);
      check_output("shape_alloc_active", voice_active_out, 4'b0001);
      lvl = env_of(0);
      for (int k = 0; k < 4; k++) begin
         wait_cycles(2);
         lvl = lvl + 16'd4;
         check_output("attack_step", env_of(0), lvl);
      end
      wait_env("attack_peak", 0, 16'hFFFF, 40000);
      wait_cycles(2);
      check_output("decay_first_step", env_of(0), 16'hFFFB);
      wait_env("decay_to_sustain", 0, 16'h8000, 20000);
      wait_cycles(6);
      check_output("sustain_hold", env_of(0), 16'h8000);

      apply_stimulus(8'hB0, 8'h48, 8'd32);
      wait_cycles(2);
      check_output("sustain_live_change", env_of(0), 16'h4000);

      apply_stimulus(8'h80, 8'd60, 8'd64);
      wait_cycles(2);
      check_output("release_step", env_of(0), 16'h3FFC);
      wait_all_idle("release_to_idle", 20000);
      check_output("release_env_zero", env_of(0), 16'h0000);
      check_output("release_note_hold", voice_note_out[6:0], 7'd60);

      apply_stimulus(8'h90, 8'd40, 8'd48);
      wait_cycles(10);
      check_output("pre_reset_env_nonzero", (env_of(0) != 16'h0), 1'b1);
      @(negedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      check_output("async_reset_notes", voice_note_out, 28'h0);
      check_output("async_reset_vel", voice_vel_out, 28'h0);
      check_output("async_reset_env", voice_env_out, 64'h0);
      check_output("async_reset_active", voice_active_out, 4'b0000);
      check_output("async_reset_pitchbend", pitchbend_out, 14'h2000);
      check_output("async_reset_mod", mod_out, 7'h00);

      @(negedge clk_in);
      rst_n_in      = 1'b1;
      midi_event    = {8'h90, 8'd60, 8'd100};
      midi_valid_in = 1'b1;
      @(negedge clk_in);
      midi_valid_in = 1'b0;
      midi_event    = '0;
      check_output("post_reset_no_tick_yet", env_of(0), 16'h0000);
      check_output("post_reset_active", voice_active_out, 4'b0001);
      @(negedge clk_in);
      check_output("post_reset_first_tick", env_of(0), 16'h0200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
